// File: rtl/sram_like_arbiter_pkg.sv
// Shared types and constants for the SRAM-like instruction/data bus arbiter.
package sram_like_arbiter_pkg;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  localparam int DEFAULT_OST_DEPTH = 4;

  // The count has to hold DEPTH itself, so it needs one more bit than a pointer.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sram_like_arbiter_tag_fifo.sv
// In-order FIFO of 1-bit source tags, one entry per outstanding bus request.
module tag_fifo
  import sram_like_arbiter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_OST_DEPTH
) (
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  logic i_pop,
  input  logic i_data,
  output logic o_full,
  output logic o_empty,
  output logic o_head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_mem [DEPTH];
  logic          w_doPush;
  logic          w_doPop;

  assign o_full   = (r_count == FULL_CNT);
  assign o_empty  = (r_count == '0);
  assign o_head   = r_mem[r_rdPtr];
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 1'b0;
    end else begin
      if (w_doPush) begin
        r_mem[r_wrPtr] <= i_data;
        r_wrPtr        <= r_wrPtr + PW'(1);
      end
      if (w_doPop) r_rdPtr <= r_rdPtr + PW'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Merges instruction and data SRAM-like masters onto one in-order bus; data wins ties.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int OST_DEPTH = DEFAULT_OST_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] resp_rdata,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  logic w_grantData;
  logic w_grantInst;
  logic w_full;
  logic w_empty;
  logic w_headTag;
  logic w_push;
  logic w_pop;
  logic w_accept;
  src_e w_pushTag;

  assign w_grantData = data_sram_req;
  assign w_grantInst = ~data_sram_req & inst_sram_req;
  assign w_pushTag   = w_grantData ? SRC_DATA : SRC_INST;

  // Full comes from registered state only, so a same-cycle pop never frees a slot early.
  assign bus_req   = (inst_sram_req | data_sram_req) & ~w_full;
  assign bus_addr  = w_grantData ? data_sram_addr  :
                     w_grantInst ? inst_sram_addr  : 32'h0;
  assign bus_wr    = w_grantData & data_sram_wr;
  assign bus_wstrb = w_grantData ? data_sram_wstrb : 4'h0;
  assign bus_wdata = w_grantData ? data_sram_wdata : 32'h0;

  assign w_accept          = bus_req & bus_addr_ok;
  assign data_sram_addr_ok = w_grantData & w_accept;
  assign inst_sram_addr_ok = w_grantInst & w_accept;

  assign w_push = w_accept;
  assign w_pop  = bus_data_ok & ~w_empty;

  // Responses come back in request order, so the FIFO head names the owner.
  assign inst_sram_data_ok = w_pop & (w_headTag == SRC_INST);
  assign data_sram_data_ok = w_pop & (w_headTag == SRC_DATA);
  assign resp_rdata        = bus_rdata;

  tag_fifo #(
    .DEPTH (OST_DEPTH)
  ) u_tagFifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pushTag),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_headTag)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed self-checking bench for sram_like_arbiter at the default depth of 4.
module tb_sram_like_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] resp_rdata;
  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int vecCount = 0;
  int errCount = 0;

  // Handshake view: {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, bus_req}
  logic [4:0]  w_hs;
  logic [68:0] w_busFields;
  int          w_count;

  assign w_hs        = {inst_sram_addr_ok, data_sram_addr_ok, inst_sram_data_ok,
                        data_sram_data_ok, bus_req};
  assign w_busFields = {bus_wr, bus_wstrb, bus_addr, bus_wdata};
  assign w_count     = int'(dut.u_tagFifo.r_count);

  sram_like_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .resp_rdata        (resp_rdata),
    .bus_req           (bus_req),
    .bus_wr            (bus_wr),
    .bus_wstrb         (bus_wstrb),
    .bus_addr          (bus_addr),
    .bus_wdata         (bus_wdata),
    .bus_addr_ok       (bus_addr_ok),
    .bus_data_ok       (bus_data_ok),
    .bus_rdata         (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic setIdle();
    inst_sram_req   = 1'b0;
    inst_sram_addr  = 32'h0;
    data_sram_req   = 1'b0;
    data_sram_wr    = 1'b0;
    data_sram_wstrb = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    bus_addr_ok     = 1'b0;
    bus_data_ok     = 1'b0;
    bus_rdata       = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    setIdle();
    @(negedge clk); #1;
    vecCount++;
    if (w_hs !== 5'b00000) begin
      errCount++; $display("[TB] FAIL reset_hs: got %b expected %b", w_hs, 5'b00000);
    end
    vecCount++;
    if (w_busFields !== 69'h0 || resp_rdata !== 32'h0) begin
      errCount++; $display("[TB] FAIL reset_bus: got %h/%h expected 0/0", w_busFields, resp_rdata);
    end
    vecCount++;
    if (w_count !== 0) begin
      errCount++; $display("[TB] FAIL reset_count: got %0d expected 0", w_count);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_priority();
    @(negedge clk);
    setIdle();
    inst_sram_req  = 1'b1; inst_sram_addr = 32'h1C000000;
    data_sram_req  = 1'b1; data_sram_addr = 32'h00000100;
    bus_addr_ok    = 1'b1;
    #1;
    vecCount++;
    if (bus_addr !== 32'h00000100) begin
      errCount++; $display("[TB] FAIL prio_addr: got %h expected %h", bus_addr, 32'h00000100);
    end
    vecCount++;
    if (w_hs !== 5'b01001) begin
      errCount++; $display("[TB] FAIL prio_hs: got %b expected %b", w_hs, 5'b01001);
    end
    // Inst-only cycle: data-side write fields must not leak onto the bus.
    @(negedge clk);
    setIdle();
    inst_sram_req   = 1'b1; inst_sram_addr = 32'h1C000004;
    data_sram_wr    = 1'b1; data_sram_wstrb = 4'hF; data_sram_wdata = 32'h55AA55AA;
    data_sram_addr  = 32'h00000200;
    #1;
    vecCount++;
    if (w_busFields !== {1'b0, 4'h0, 32'h1C000004, 32'h0}) begin
      errCount++; $display("[TB] FAIL inst_only_bus: got %h expected %h", w_busFields,
                           {1'b0, 4'h0, 32'h1C000004, 32'h0});
    end
    vecCount++;
    if (w_hs !== 5'b00001) begin
      errCount++; $display("[TB] FAIL inst_only_hs: got %b expected %b", w_hs, 5'b00001);
    end
    @(negedge clk);
    setIdle();
    bus_data_ok = 1'b1;
    #1;
    vecCount++;
    if (w_hs !== 5'b00010) begin
      errCount++; $display("[TB] FAIL prio_resp: got %b expected %b", w_hs, 5'b00010);
    end
    @(negedge clk);
    setIdle();
  endtask

  task automatic test_order();
    @(negedge clk);
    setIdle();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000000; bus_addr_ok = 1'b1;
    #1;
    vecCount++;
    if (w_hs !== 5'b10001) begin
      errCount++; $display("[TB] FAIL order_inst_acc: got %b expected %b", w_hs, 5'b10001);
    end
    @(negedge clk);
    setIdle();
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_wstrb = 4'hF;
    data_sram_addr = 32'h00000200; data_sram_wdata = 32'hDEADBEEF; bus_addr_ok = 1'b1;
    #1;
    vecCount++;
    if (w_busFields !== {1'b1, 4'hF, 32'h00000200, 32'hDEADBEEF}) begin
      errCount++; $display("[TB] FAIL order_store_bus: got %h expected %h", w_busFields,
                           {1'b1, 4'hF, 32'h00000200, 32'hDEADBEEF});
    end
    vecCount++;
    if (w_hs !== 5'b01001) begin
      errCount++; $display("[TB] FAIL order_store_acc: got %b expected %b", w_hs, 5'b01001);
    end
    @(negedge clk);
    setIdle();
    bus_data_ok = 1'b1; bus_rdata = 32'h02800000;
    #1;
    vecCount++;
    if (w_hs !== 5'b00100 || resp_rdata !== 32'h02800000) begin
      errCount++; $display("[TB] FAIL order_first: got %b/%h expected %b/%h", w_hs, resp_rdata,
                           5'b00100, 32'h02800000);
    end
    @(negedge clk);
    bus_rdata = 32'h0;
    #1;
    vecCount++;
    if (w_hs !== 5'b00010) begin
      errCount++; $display("[TB] FAIL order_second: got %b expected %b", w_hs, 5'b00010);
    end
    @(negedge clk);
    setIdle();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      setIdle();
      inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000000 + 32'(4 * i); bus_addr_ok = 1'b1;
      #1;
      vecCount++;
      if (w_hs !== 5'b10001) begin
        errCount++; $display("[TB] FAIL fill_%0d: got %b expected %b", i, w_hs, 5'b10001);
      end
    end
    @(negedge clk);
    #1;
    vecCount++;
    if (w_hs !== 5'b00000 || w_count !== 4) begin
      errCount++; $display("[TB] FAIL full_block: got %b cnt %0d expected %b cnt 4", w_hs, w_count,
                           5'b00000);
    end
    // Pop with a pending request while full: still no bus_req, no push this cycle.
    bus_data_ok = 1'b1;
    #1;
    vecCount++;
    if (w_hs !== 5'b00100) begin
      errCount++; $display("[TB] FAIL full_pop: got %b expected %b", w_hs, 5'b00100);
    end
    @(negedge clk);
    bus_data_ok = 1'b0; bus_addr_ok = 1'b0;
    #1;
    vecCount++;
    if (w_count !== 3 || w_hs !== 5'b00001) begin
      errCount++; $display("[TB] FAIL full_release: got cnt %0d hs %b expected cnt 3 hs %b",
                           w_count, w_hs, 5'b00001);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      setIdle();
      bus_data_ok = 1'b1;
      #1;
      vecCount++;
      if (w_hs !== 5'b00100) begin
        errCount++; $display("[TB] FAIL drain_%0d: got %b expected %b", i, w_hs, 5'b00100);
      end
    end
    @(negedge clk);
    setIdle();
    #1;
    vecCount++;
    if (w_count !== 0) begin
      errCount++; $display("[TB] FAIL drain_count: got %0d expected 0", w_count);
    end
  endtask

  task automatic test_empty_data_ok();
    @(negedge clk);
    setIdle();
    bus_data_ok = 1'b1; bus_rdata = 32'h13572468;
    #1;
    vecCount++;
    if (w_hs !== 5'b00000) begin
      errCount++; $display("[TB] FAIL empty_resp: got %b expected %b", w_hs, 5'b00000);
    end
    @(negedge clk);
    setIdle();
    #1;
    vecCount++;
    if (w_count !== 0) begin
      errCount++; $display("[TB] FAIL empty_count: got %0d expected 0", w_count);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    setIdle();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000010; bus_addr_ok = 1'b1;
    #1;
    vecCount++;
    if (w_hs !== 5'b10001) begin
      errCount++; $display("[TB] FAIL b2b_inst: got %b expected %b", w_hs, 5'b10001);
    end
    @(negedge clk);
    setIdle();
    data_sram_req = 1'b1; data_sram_addr = 32'h00000300; bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1; bus_rdata = 32'hCAFEF00D;
    #1;
    vecCount++;
    if (w_hs !== 5'b01101 || resp_rdata !== 32'hCAFEF00D) begin
      errCount++; $display("[TB] FAIL b2b_pushpop: got %b/%h expected %b/%h", w_hs, resp_rdata,
                           5'b01101, 32'hCAFEF00D);
    end
    @(negedge clk);
    setIdle();
    #1;
    vecCount++;
    if (w_count !== 1) begin
      errCount++; $display("[TB] FAIL b2b_count: got %0d expected 1", w_count);
    end
    bus_data_ok = 1'b1;
    #1;
    vecCount++;
    if (w_hs !== 5'b00010) begin
      errCount++; $display("[TB] FAIL b2b_data_resp: got %b expected %b", w_hs, 5'b00010);
    end
    @(negedge clk);
    setIdle();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      setIdle();
      inst_sram_req = 1'b1; inst_sram_addr = 32'h1C000020; bus_addr_ok = 1'b1;
    end
    @(negedge clk);
    setIdle();
    #1;
    vecCount++;
    if (w_count !== 3) begin
      errCount++; $display("[TB] FAIL mid_pre_count: got %0d expected 3", w_count);
    end
    reset = 1'b1;
    bus_data_ok = 1'b1;
    #1;
    vecCount++;
    if (w_count !== 0 || w_hs !== 5'b00000 || w_busFields !== 69'h0) begin
      errCount++; $display("[TB] FAIL mid_async: got cnt %0d hs %b bus %h expected 0", w_count,
                           w_hs, w_busFields);
    end
    @(negedge clk);
    #1;
    vecCount++;
    if (w_count !== 0 || w_hs !== 5'b00000) begin
      errCount++; $display("[TB] FAIL mid_held: got cnt %0d hs %b expected 0", w_count, w_hs);
    end
    reset = 1'b0;
    @(negedge clk);
    #1;
    vecCount++;
    if (w_hs !== 5'b00000 || w_count !== 0) begin
      errCount++; $display("[TB] FAIL mid_lost_tags: got hs %b cnt %0d expected 0", w_hs, w_count);
    end
    @(negedge clk);
    setIdle();
  endtask

  initial begin
    setIdle();
    reset = 1'b1;
    test_reset();
    test_priority();
    test_order();
    test_full();
    test_empty_data_ok();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
